// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu_mc_pkg
//  Brief   : Opcode/state types and legality helper for the multi-cycle ALU.
//            Opcode 11 (MUL) is legal only when ALU_MC_MUL_EN is defined.
//  Revision: 1.0 - initial release
// ============================================================================
package alu_mc_pkg;

    localparam int ALU_MC_FUNC_W = 4;

    typedef enum logic [ALU_MC_FUNC_W-1:0] {
        FN_ADD = 4'd0,
        FN_SUB = 4'd1,
        FN_AND = 4'd2,
        FN_OR  = 4'd3,
        FN_XOR = 4'd4,
        FN_INV = 4'd5,
        FN_ADC = 4'd6,
        FN_SBB = 4'd7,
        FN_SHL = 4'd8,
        FN_SHR = 4'd9,
        FN_SAR = 4'd10,
        FN_MUL = 4'd11
    } alu_mc_func_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } alu_mc_state_e;

    function automatic logic is_legal(input logic [ALU_MC_FUNC_W-1:0] func);
`ifdef ALU_MC_MUL_EN
        return (func <= 4'd11);
`else
        return (func <= 4'd10);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_shifter.sv
`default_nettype none
// ============================================================================
//  Module  : alu_mc_shifter
//  Brief   : Combinational barrel shifter (SHL/SHR/SAR) with carry-out and
//            handling of shift amounts at or beyond the data width.
//  Revision: 1.0 - initial release
// ============================================================================
module alu_mc_shifter
    import alu_mc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] amt_i,
    input  alu_mc_func_e      func_i,
    output logic [DATA_W-1:0] res_o,
    output logic              carry_o
);

    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int MSB     = DATA_W - 1;
    localparam logic [DATA_W-1:0] LIMIT = DATA_W[DATA_W-1:0];

    logic               over_w;
    logic [SHAMT_W-1:0] sh_w;
    logic [DATA_W:0]    shl_w;
    logic [DATA_W:0]    shr_w;
    logic [DATA_W:0]    sar_w;

    assign over_w = (amt_i >= LIMIT);
    assign sh_w   = amt_i[SHAMT_W-1:0];

    // One guard bit beside the operand catches the last bit shifted out.
    assign shl_w = {1'b0, a_i} << sh_w;
    assign shr_w = {a_i, 1'b0} >> sh_w;
    assign sar_w = $signed({a_i, 1'b0}) >>> sh_w;

    always_comb begin
        res_o   = '0;
        carry_o = 1'b0;
        case (func_i)
            FN_SHL: begin
                if (!over_w) begin
                    res_o   = shl_w[MSB:0];
                    carry_o = shl_w[DATA_W];
                end
            end
            FN_SHR: begin
                if (!over_w) begin
                    res_o   = shr_w[DATA_W:1];
                    carry_o = shr_w[0];
                end
            end
            FN_SAR: begin
                if (over_w) begin
                    res_o   = {DATA_W{a_i[MSB]}};
                    carry_o = a_i[MSB];
                end else begin
                    res_o   = sar_w[DATA_W:1];
                    carry_o = sar_w[0];
                end
            end
            default: begin
                res_o   = '0;
                carry_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module  : alu_mc
//  Brief   : Multi-cycle ALU with valid/ready in/out handshakes, registered
//            result and flags. Define ALU_MC_MUL_EN to build the iterative
//            shift-add multiplier (opcode 11); otherwise opcode 11 is illegal.
//  Revision: 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [3:0]        alu_func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero_flag,
    output logic              positive_flag,
    output logic              carry_flag,
    output logic              signed_overflow,
    output logic              illegal_op
);

    localparam int MSB = DATA_W - 1;

    alu_mc_state_e     state_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              pos_q;
    logic              carry_q;
    logic              ovf_q;
    logic              ill_q;

    alu_mc_func_e      func_w;
    logic              accept_w;
    logic [DATA_W:0]   sum_w;
    logic [DATA_W-1:0] res_d;
    logic              carry_d;
    logic              ovf_d;
    logic              ill_d;
    logic [DATA_W-1:0] sh_res_w;
    logic              sh_carry_w;

`ifdef ALU_MC_MUL_EN
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_W - 1);

    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [SHAMT_W-1:0]  cnt_q;
    logic [2*DATA_W-1:0] mul_sum_w;

    assign mul_sum_w = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    assign func_w   = alu_mc_func_e'(alu_func);
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept_w = in_valid && in_ready;

    assign out_valid       = out_valid_q;
    assign alu_result      = result_q;
    assign zero_flag       = zero_q;
    assign positive_flag   = pos_q;
    assign carry_flag      = carry_q;
    assign signed_overflow = ovf_q;
    assign illegal_op      = ill_q;

    alu_mc_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .a_i     (operand_a),
        .amt_i   (operand_b),
        .func_i  (func_w),
        .res_o   (sh_res_w),
        .carry_o (sh_carry_w)
    );

    // Single-cycle datapath; carry/overflow default to their held values.
    always_comb begin
        sum_w   = '0;
        res_d   = '0;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        ill_d   = 1'b0;
        if (!is_legal(alu_func)) begin
            ill_d = 1'b1;
        end else begin
            case (func_w)
                FN_ADD, FN_ADC: begin
                    sum_w   = {1'b0, operand_a} + {1'b0, operand_b}
                            + {{DATA_W{1'b0}}, (func_w == FN_ADC) & carry_q};
                    res_d   = sum_w[MSB:0];
                    carry_d = sum_w[DATA_W];
                    ovf_d   = (operand_a[MSB] == operand_b[MSB]) && (res_d[MSB] != operand_a[MSB]);
                end
                FN_SUB, FN_SBB: begin
                    sum_w   = {1'b0, operand_a} - {1'b0, operand_b}
                            - {{DATA_W{1'b0}}, (func_w == FN_SBB) & ~carry_q};
                    res_d   = sum_w[MSB:0];
                    carry_d = ~sum_w[DATA_W];
                    ovf_d   = (operand_a[MSB] != operand_b[MSB]) && (res_d[MSB] != operand_a[MSB]);
                end
                FN_AND: res_d = operand_a & operand_b;
                FN_OR:  res_d = operand_a | operand_b;
                FN_XOR: res_d = operand_a ^ operand_b;
                FN_INV: res_d = ~operand_a;
                FN_SHL, FN_SHR, FN_SAR: begin
                    res_d = sh_res_w;
                    if (operand_b != '0) begin
                        carry_d = sh_carry_w;
                    end
                end
                default: res_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            pos_q       <= 1'b1;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
`ifdef ALU_MC_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept_w) begin
`ifdef ALU_MC_MUL_EN
                        // First partial product is folded into the accept edge.
                        if (func_w == FN_MUL) begin
                            state_q     <= MUL_BUSY;
                            out_valid_q <= 1'b0;
                            acc_q       <= operand_b[0] ? {{DATA_W{1'b0}}, operand_a} : '0;
                            mcand_q     <= {{(DATA_W-1){1'b0}}, operand_a, 1'b0};
                            mplier_q    <= operand_b >> 1;
                            cnt_q       <= SHAMT_W'(1);
                        end else
`endif
                        begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= res_d;
                            carry_q     <= carry_d;
                            ovf_q       <= ovf_d;
                            ill_q       <= ill_d;
                            if (!ill_d) begin
                                zero_q <= (res_d == '0);
                                pos_q  <= ~res_d[MSB];
                            end
                        end
                    end else if ((state_q == DONE) && out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef ALU_MC_MUL_EN
                MUL_BUSY: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_sum_w[MSB:0];
                        carry_q     <= |mul_sum_w[2*DATA_W-1:DATA_W];
                        ovf_q       <= |mul_sum_w[2*DATA_W-1:DATA_W];
                        zero_q      <= (mul_sum_w[MSB:0] == '0);
                        pos_q       <= ~mul_sum_w[MSB];
                        ill_q       <= 1'b0;
                    end else begin
                        acc_q    <= mul_sum_w;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + SHAMT_W'(1);
                    end
                end
`endif
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module  : tb_alu_mc
//  Brief   : Self-checking bench for alu_mc (DATA_W=8): directed table,
//            handshake corner sequences and randomized ops against a model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam int W = 8;
`ifdef ALU_MC_MUL_EN
    localparam int MUL_LAT = W;
`else
    localparam int MUL_LAT = 1;
`endif

    typedef struct {
        logic [3:0] f;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       z;
        logic       p;
        logic       c;
        logic       v;
        logic       ill;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [3:0] alu_func;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_result;
    logic       zero_flag;
    logic       positive_flag;
    logic       carry_flag;
    logic       signed_overflow;
    logic       illegal_op;

    int n_vec = 0;
    int n_err = 0;
    bit m_z = 1'b1, m_p = 1'b1, m_c = 1'b0, m_v = 1'b0;
    vec_t tbl [14];

    alu_mc #(.DATA_W(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .operand_a       (operand_a),
        .operand_b       (operand_b),
        .alu_func        (alu_func),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .alu_result      (alu_result),
        .zero_flag       (zero_flag),
        .positive_flag   (positive_flag),
        .carry_flag      (carry_flag),
        .signed_overflow (signed_overflow),
        .illegal_op      (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t e);
        chk(tag, "out_valid", out_valid, 1);
        chk(tag, "result", alu_result, e.r);
        chk(tag, "zero", zero_flag, e.z);
        chk(tag, "positive", positive_flag, e.p);
        chk(tag, "carry", carry_flag, e.c);
        chk(tag, "overflow", signed_overflow, e.v);
        chk(tag, "illegal", illegal_op, e.ill);
    endtask

    task automatic set_model(input vec_t e);
        m_z = e.z; m_p = e.p; m_c = e.c; m_v = e.v;
    endtask

    // Reference model: plain integer arithmetic on the current model flags.
    function automatic vec_t model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        vec_t  e;
        longint ua = a, ub = b, s = 0, rr = 0, sa, sb, sr;
        int    sh = b;
        sa = a[7] ? ua - 256 : ua;
        sb = b[7] ? ub - 256 : ub;
        e.f = f; e.a = a; e.b = b; e.c = m_c; e.v = m_v; e.ill = 1'b0; e.lat = 1;
        case (f)
            4'd0, 4'd6: begin
                s = ua + ub + ((f == 4'd6 && m_c) ? 1 : 0);
                sr = sa + sb + ((f == 4'd6 && m_c) ? 1 : 0);
                rr = s; e.c = (s > 255); e.v = (sr > 127) || (sr < -128);
            end
            4'd1, 4'd7: begin
                s = ua - ub - ((f == 4'd7 && !m_c) ? 1 : 0);
                sr = sa - sb - ((f == 4'd7 && !m_c) ? 1 : 0);
                rr = s; e.c = (s >= 0); e.v = (sr > 127) || (sr < -128);
            end
            4'd2: rr = ua & ub;
            4'd3: rr = ua | ub;
            4'd4: rr = ua ^ ub;
            4'd5: rr = 255 - ua;
            4'd8: begin
                if (sh == 0) rr = ua;
                else if (sh >= W) begin rr = 0; e.c = 1'b0; end
                else begin rr = ua << sh; e.c = ((ua >> (W - sh)) & 1) != 0; end
            end
            4'd9: begin
                if (sh == 0) rr = ua;
                else if (sh >= W) begin rr = 0; e.c = 1'b0; end
                else begin rr = ua >> sh; e.c = ((ua >> (sh - 1)) & 1) != 0; end
            end
            4'd10: begin
                if (sh == 0) rr = ua;
                else if (sh >= W) begin rr = (sa < 0) ? 255 : 0; e.c = (sa < 0); end
                else begin rr = sa >>> sh; e.c = ((sa >>> (sh - 1)) & 1) != 0; end
            end
`ifdef ALU_MC_MUL_EN
            4'd11: begin
                s = ua * ub; rr = s; e.c = (s > 255); e.v = (s > 255); e.lat = W;
            end
`endif
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.r = 8'h00; e.z = m_z; e.p = m_p;
        end else begin
            e.r = rr[7:0]; e.z = (e.r == 8'h00); e.p = ~e.r[7];
        end
        return e;
    endfunction

    // Issue one op from IDLE with out_ready=1 and check latency and outputs.
    task automatic run_op(input string tag, input vec_t e);
        int lat;
        @(negedge clk);
        chk(tag, "in_ready_idle", in_ready, 1);
        in_valid = 1'b1; alu_func = e.f; operand_a = e.a; operand_b = e.b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            chk(tag, "in_ready_busy", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        chk(tag, "latency", lat, e.lat);
        chk_outs(tag, e);
        set_model(e);
    endtask

    initial begin
        vec_t e1, e2;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_func = 4'd0; operand_a = 8'h00; operand_b = 8'h00;

        tbl[0]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[1]  = '{4'd1,  8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[2]  = '{4'd7,  8'h05, 8'h02, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[3]  = '{4'd10, 8'h80, 8'h09, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[4]  = '{4'd8,  8'h81, 8'h01, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[5]  = '{4'd9,  8'h5A, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[6]  = '{4'd6,  8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[7]  = '{4'd2,  8'hF0, 8'h0F, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[8]  = '{4'd5,  8'h00, 8'h33, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[9]  = '{4'd13, 8'h55, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[10] = '{4'd9,  8'h81, 8'h08, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[11] = '{4'd10, 8'h40, 8'h03, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[12] = '{4'd1,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1};
`ifdef ALU_MC_MUL_EN
        tbl[13] = '{4'd11, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, MUL_LAT};
`else
        tbl[13] = '{4'd11, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, MUL_LAT};
`endif

        repeat (2) @(negedge clk);
        chk("reset", "out_valid", out_valid, 0);
        chk("reset", "result", alu_result, 0);
        chk("reset", "zero", zero_flag, 1);
        chk("reset", "positive", positive_flag, 1);
        chk("reset", "carry", carry_flag, 0);
        chk("reset", "overflow", signed_overflow, 0);
        chk("reset", "illegal", illegal_op, 0);
        chk("reset", "in_ready", in_ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i]);
        end

        // Back-to-back SUB then SBB: SBB sees the SUB borrow.
        @(negedge clk);
        e1 = model(4'd1, 8'h00, 8'h01);
        in_valid = 1'b1; alu_func = 4'd1; operand_a = 8'h00; operand_b = 8'h01;
        @(negedge clk);
        chk_outs("b2b_sub", e1);
        set_model(e1);
        e2 = model(4'd7, 8'h05, 8'h02);
        alu_func = 4'd7; operand_a = 8'h05; operand_b = 8'h02;
        chk("b2b", "in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_outs("b2b_sbb", e2);
        chk("b2b", "sbb_result", alu_result, 8'h02);
        chk("b2b", "sbb_carry", carry_flag, 1);
        set_model(e2);

        // Backpressure: ADD 3+4 held 5 cycles, competing request ignored.
        @(negedge clk);
        e1 = model(4'd0, 8'h03, 8'h04);
        out_ready = 1'b0; in_valid = 1'b1; alu_func = 4'd0; operand_a = 8'h03; operand_b = 8'h04;
        @(negedge clk);
        set_model(e1);
        e2 = model(4'd1, 8'h09, 8'h01);
        alu_func = 4'd1; operand_a = 8'h09; operand_b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            chk_outs("hold", e1);
            chk("hold", "in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk("hold", "result_7", alu_result, 8'h07);
        out_ready = 1'b1;
        #1;
        chk("release", "in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_outs("release_sub", e2);
        chk("release", "result_8", alu_result, 8'h08);
        set_model(e2);
        @(negedge clk);
        chk("release", "idle_out_valid", out_valid, 0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] f;
            logic [7:0] a, b;
            f = 4'($urandom_range(0, 15));
            a = 8'($urandom);
            b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 11)) : 8'($urandom);
            run_op($sformatf("rnd%0d", i), model(f, a, b));
        end

        // Reset in cycle 4 of a long operation (MUL, or a held ADD without it).
        @(negedge clk);
`ifdef ALU_MC_MUL_EN
        alu_func = 4'd11; operand_a = 8'hFF; operand_b = 8'hFF;
`else
        out_ready = 1'b0; alu_func = 4'd0; operand_a = 8'h7F; operand_b = 8'h01;
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid", "busy_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", "out_valid", out_valid, 0);
        chk("rst_mid", "zero", zero_flag, 1);
        chk("rst_mid", "positive", positive_flag, 1);
        chk("rst_mid", "carry", carry_flag, 0);
        chk("rst_mid", "overflow", signed_overflow, 0);
        chk("rst_mid", "result", alu_result, 0);
        chk("rst_mid", "in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        m_z = 1'b1; m_p = 1'b1; m_c = 1'b0; m_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst", "no_output", out_valid, 0);
        end
        chk("post_rst", "in_ready", in_ready, 1);
        run_op("post_rst_add", model(4'd0, 8'h03, 8'h04));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle ALU. It adds carry-chained arithmetic (ADC/SBB), barrel shifts and an iterative multiply.
- Results and flags are held in registers.
- Operands enter through a valid/ready handshake and results leave through a second valid/ready handshake.
- The block sits between the register-file read stage and writeback. The next-generation core's control FSM drives it.

Parameters:
- DATA_W, 8, operand/result width; legal range 4..32.
- SHAMT_W, $clog2(DATA_W), derived; width of the shift amount taken from operand_b.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- operand_a  in  DATA_W  first operand.
- operand_b  in  DATA_W  second operand / shift amount.
- alu_func  in  4  operation code (alu_mc_func_e).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- alu_result  out  DATA_W  registered result.
- zero_flag  out  1  registered: result == 0.
- positive_flag  out  1  registered: ~result[MSB].
- carry_flag  out  1  registered carry / no-borrow.
- signed_overflow  out  1  registered signed overflow.
- illegal_op  out  1  accepted code was unsupported; valid with out_valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, alu_result=0, zero_flag=1, positive_flag=1, carry_flag=0, signed_overflow=0, illegal_op=0. Reset mid-MUL abandons the operation with no output.
- A transaction is accepted on in_valid && in_ready. Operands and func are captured at acceptance.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back throughput of one op per cycle for single-cycle ops.
- FSM:
  - IDLE: on accept, single-cycle op goes to DONE; MUL goes to MUL_BUSY.
  - MUL_BUSY: counter counts DATA_W iterations, then goes to DONE.
  - DONE: out_valid=1; result/flags held stable while out_ready=0.
    - On out_ready with a new accept: load the next op (DONE or MUL_BUSY).
    - On out_ready without a new accept: go to IDLE.
- Latency: single-cycle ops give out_valid the cycle after acceptance (T+1). MUL gives out_valid at T+DATA_W.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INV (~a), 6 ADC, 7 SBB, 8 SHL, 9 SHR, 10 SAR, 11 MUL, 12-15 illegal.
- ADD/ADC: {c,r}=a+b(+carry_flag). Overflow when a and b have the same sign and r's sign differs.
- SUB/SBB: r=a-b(-~carry_flag); carry = no borrow. Overflow when a and b have different signs and r's sign differs from a.
- The carry_flag read by ADC/SBB is the register value at the acceptance edge. For a back-to-back accept, this is the flag of the result being consumed that cycle.
- AND/OR/XOR/INV: carry and overflow retain their previous values.
- Shifts:
  - Shift amount = operand_b. Amount 0: r=a, carry retained.
  - 1..DATA_W-1: carry = last bit shifted out.
  - Amount >= DATA_W: SHL/SHR give r=0, carry=0; SAR gives r={DATA_W{a[MSB]}}, carry=a[MSB].
  - Overflow retained for all shifts.
- MUL: unsigned shift-add, one partial product per cycle, 2*DATA_W accumulator. r = low half; carry = overflow = (high half != 0).
- Zero and positive flags are always computed from r.
- Illegal code: completes in 1 cycle with r=0 and illegal_op=1. All flags are retained, including zero and positive.
- Inputs while busy are ignored (in_ready=0); no abort port.

Optional Feature:
- Macro: ALU_MC_MUL_EN.
- Defined: MUL is implemented as above, with the MUL_BUSY state and counter present.
- Undefined: no multiplier, counter or MUL_BUSY logic. Opcode 11 is handled as illegal (1 cycle, illegal_op=1, r=0).

Decomposition:
- Package alu_mc_pkg holds:
  - alu_mc_func_e (4-bit enum).
  - alu_mc_state_e (IDLE, MUL_BUSY, DONE).
  - function is_legal(func).
  - localparam ALU_MC_FUNC_W=4.
- One sub-module, alu_mc_shifter: combinational barrel shifter (SHL/SHR/SAR, result + carry-out, over-range handling), parametrised by DATA_W.

Test Plan:
- DATA_W=8, ADD 0x7F+0x01 -> out_valid at T+1, r=0x80, signed_overflow=1, carry=0, positive=0.
- SUB 0x00-0x01 -> r=0xFF, carry=0; then back-to-back SBB 0x05-0x02 -> r=0x02, carry=1.
- SAR 0x80 by 9 -> r=0xFF, carry=1. SHL 0x81 by 1 -> r=0x02, carry=1. SHR by 0 -> r=a, carry retained.
- MUL 0x10*0x10 with ALU_MC_MUL_EN defined -> out_valid at T+8, r=0x00, zero=1, carry=1, in_ready=0 during busy. Without the macro -> illegal_op=1 at T+1.
- Hold out_ready=0 for 5 cycles after ADD 3+4 -> r=0x07 stable, in_ready=0, a new in_valid is ignored. Release -> same-cycle accept of the next op.
- Assert rst_n=0 mid-MUL (cycle 4) -> outputs immediately take reset values (out_valid=0, zero_flag=1). After release, the block is in IDLE with in_ready=1.
